// File: rtl/quick_spi_arbiter.sv
// Round-robin sharing of one quick_spi master between two command ports, with a
// BUSY watchdog and an enforced idle gap between consecutive transactions.
module quick_spi_arbiter #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int GAP_CYCLES     = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0_valid,
   input  logic [15:0] req0_data,
   input  logic [1:0]  req0_slave,
   input  logic        req0_operation,
   output logic        req0_ready,
   output logic        req0_done,
   output logic        req0_error,
   output logic [7:0]  req0_rdata,
   input  logic        req1_valid,
   input  logic [15:0] req1_data,
   input  logic [1:0]  req1_slave,
   input  logic        req1_operation,
   output logic        req1_ready,
   output logic        req1_done,
   output logic        req1_error,
   output logic [7:0]  req1_rdata,
   output logic        spi_enable,
   output logic        spi_start_transaction,
   output logic [15:0] spi_outgoing_data,
   output logic [1:0]  spi_slave,
   output logic        spi_operation,
   input  logic        spi_end_of_transaction,
   input  logic [7:0]  spi_incoming_data
);
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic            last_q, last_d;
   logic            port_q, port_d;
   logic            en_q, en_d;
   logic [15:0]     data_q, data_d;
   logic [1:0]      slave_q, slave_d;
   logic            op_q, op_d;
   logic [1:0]      done_q, done_d;
   logic [1:0]      err_q, err_d;
   logic [1:0][7:0] rdata_q, rdata_d;

   logic any_valid;
   logic grant_sel;
   logic accept;

   // On a tie the port that was not served last wins.
   assign any_valid  = req0_valid | req1_valid;
   assign grant_sel  = (req0_valid & req1_valid) ? ~last_q : req1_valid;
   assign accept     = reset_n & (state_q == ST_IDLE) & any_valid;
   assign req0_ready = accept & ~grant_sel;
   assign req1_ready = accept & grant_sel;

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      gap_d   = gap_q;
      last_d  = last_q;
      port_d  = port_q;
      en_d    = en_q;
      data_d  = data_q;
      slave_d = slave_q;
      op_d    = op_q;
      done_d  = '0;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               port_d  = grant_sel;
               last_d  = grant_sel;
               data_d  = grant_sel ? req1_data : req0_data;
               slave_d = grant_sel ? req1_slave : req0_slave;
               op_d    = grant_sel ? req1_operation : req0_operation;
               en_d    = 1'b1;
               tmo_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Completion wins over a timeout landing in the same cycle.
            if (spi_end_of_transaction) begin
               done_d[port_q]  = 1'b1;
               err_d[port_q]   = 1'b0;
               rdata_d[port_q] = spi_incoming_data;
               en_d            = 1'b0;
               gap_d           = '0;
               state_d         = ST_GAP;
            end else if (tmo_q == TMO_LAST) begin
               done_d[port_q] = 1'b1;
               err_d[port_q]  = 1'b1;
               en_d           = 1'b0;
               gap_d          = '0;
               state_d        = ST_GAP;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = ST_IDLE;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         tmo_q   <= '0;
         gap_q   <= '0;
         last_q  <= 1'b1;
         port_q  <= 1'b0;
         en_q    <= 1'b0;
         data_q  <= '0;
         slave_q <= '0;
         op_q    <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         gap_q   <= gap_d;
         last_q  <= last_d;
         port_q  <= port_d;
         en_q    <= en_d;
         data_q  <= data_d;
         slave_q <= slave_d;
         op_q    <= op_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   assign spi_enable            = en_q;
   assign spi_start_transaction = en_q;
   assign spi_outgoing_data     = data_q;
   assign spi_slave             = slave_q;
   assign spi_operation         = op_q;
   assign req0_done             = done_q[0];
   assign req1_done             = done_q[1];
   assign req0_error            = err_q[0];
   assign req1_error            = err_q[1];
   assign req0_rdata            = rdata_q[0];
   assign req1_rdata            = rdata_q[1];

endmodule

// File: tb/tb_quick_spi_arbiter.sv
// Bench for quick_spi_arbiter: a transaction-schedule model predicts every output each
// cycle while directed and random requesters plus a latency-programmable SPI responder drive it.
module tb_quick_spi_arbiter;
   localparam int TMO   = 16;
   localparam int GAP   = 2;
   localparam int NEVER = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [15:0] req0_data = '0, req1_data = '0;
   logic [1:0]  req0_slave = '0, req1_slave = '0;
   logic        req0_operation = 1'b0, req1_operation = 1'b0;
   logic        req0_ready, req1_ready, req0_done, req1_done, req0_error, req1_error;
   logic [7:0]  req0_rdata, req1_rdata;
   logic        spi_enable, spi_start_transaction;
   logic [15:0] spi_outgoing_data;
   logic [1:0]  spi_slave;
   logic        spi_operation;
   logic        spi_end_of_transaction = 1'b0;
   logic [7:0]  spi_incoming_data = '0;

   quick_spi_arbiter #(.TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_slave(req0_slave),
      .req0_operation(req0_operation), .req0_ready(req0_ready), .req0_done(req0_done),
      .req0_error(req0_error), .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_slave(req1_slave),
      .req1_operation(req1_operation), .req1_ready(req1_ready), .req1_done(req1_done),
      .req1_error(req1_error), .req1_rdata(req1_rdata),
      .spi_enable(spi_enable), .spi_start_transaction(spi_start_transaction),
      .spi_outgoing_data(spi_outgoing_data), .spi_slave(spi_slave),
      .spi_operation(spi_operation), .spi_end_of_transaction(spi_end_of_transaction),
      .spi_incoming_data(spi_incoming_data)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // schedule model of the current transaction
   int         free_at, en_from, en_to, done_at, done_port, lat_k, last_port;
   bit         done_err;
   logic [7:0] done_byte;
   logic [7:0] exp_rdata [2];
   logic [15:0] exp_data;
   logic [1:0] exp_slave;
   logic       exp_op;

   // requesters and knobs
   bit          pend [2];
   bit          wait_done [2];
   logic [15:0] cmd_data [2];
   logic [1:0]  cmd_slave [2];
   bit          cmd_op [2];
   bit          rst_req = 1'b0, rand_rst = 1'b0, auto_req = 1'b0, keep_valid = 1'b0;
   bit          spur_en = 1'b0, spur_force = 1'b0;
   int          lat_q [$];
   logic [7:0]  byte_q [$];

   // observations taken from the DUT pins
   int          rdy_cyc [2];
   int          done_cyc [2];
   bit          done_err_seen [2];
   bit          en_at_done [2];
   logic [7:0]  done_rd [2];
   int          n_done_act = 0;
   int          act_grants [$];
   logic [15:0] busy_data = '0;
   logic        busy_op = 1'b0;
   int          exp_order [4] = '{0, 1, 0, 1};

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic new_cmd(int p, logic [15:0] d, logic [1:0] s, bit op);
      pend[p]      = 1'b1;
      cmd_data[p]  = d;
      cmd_slave[p] = s;
      cmd_op[p]    = op;
   endtask

   task automatic model_reset();
      free_at      = cyc + 1;
      en_from      = 0;
      en_to        = -1;
      done_at      = -1;
      lat_k        = NEVER;
      exp_data     = '0;
      exp_slave    = '0;
      exp_op       = 1'b0;
      exp_rdata[0] = '0;
      exp_rdata[1] = '0;
      last_port    = 1;
      wait_done[0] = 1'b0;
      wait_done[1] = 1'b0;
   endtask

   function automatic int pick_lat();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return NEVER;
      if (r == 1) return TMO - 1;
      if (r == 2) return TMO - 2;
      return int'($urandom_range(0, 12));
   endfunction

   task automatic compare_and_update();
      bit en_exp;
      int gp, k, len;
      en_exp = (cyc >= en_from) && (cyc <= en_to);
      gp = -1;
      if (reset_n && cyc >= free_at && (req0_valid || req1_valid))
         gp = (req0_valid && req1_valid) ? 1 - last_port : (req1_valid ? 1 : 0);
      if (cyc == done_at && !done_err) exp_rdata[done_port] = done_byte;

      check("ready0", req0_ready, gp == 0);
      check("ready1", req1_ready, gp == 1);
      check("spi_enable", spi_enable, en_exp);
      check("spi_start", spi_start_transaction, en_exp);
      check("spi_data", spi_outgoing_data, exp_data);
      check("spi_slave", spi_slave, exp_slave);
      check("spi_op", spi_operation, exp_op);
      check("done0", req0_done, (cyc == done_at) && (done_port == 0));
      check("done1", req1_done, (cyc == done_at) && (done_port == 1));
      if (cyc == done_at)
         check("error", (done_port == 1) ? req1_error : req0_error, done_err);
      check("rdata0", req0_rdata, exp_rdata[0]);
      check("rdata1", req1_rdata, exp_rdata[1]);

      if (req0_ready) begin rdy_cyc[0] = cyc; act_grants.push_back(0); end
      if (req1_ready) begin rdy_cyc[1] = cyc; act_grants.push_back(1); end
      if (req0_done) begin
         done_cyc[0] = cyc; done_err_seen[0] = req0_error; done_rd[0] = req0_rdata;
         en_at_done[0] = spi_enable; n_done_act++;
      end
      if (req1_done) begin
         done_cyc[1] = cyc; done_err_seen[1] = req1_error; done_rd[1] = req1_rdata;
         en_at_done[1] = spi_enable; n_done_act++;
      end
      if (spi_enable) begin busy_data = spi_outgoing_data; busy_op = spi_operation; end

      if (!reset_n) begin
         model_reset();
      end else begin
         if (cyc == done_at) wait_done[done_port] = 1'b0;
         if (gp >= 0) begin
            last_port     = gp;
            pend[gp]      = 1'b0;
            wait_done[gp] = 1'b1;
            exp_data  = (gp == 1) ? req1_data : req0_data;
            exp_slave = (gp == 1) ? req1_slave : req0_slave;
            exp_op    = (gp == 1) ? req1_operation : req0_operation;
            if (lat_q.size() > 0) k = lat_q.pop_front();
            else k = pick_lat();
            if (byte_q.size() > 0) done_byte = byte_q.pop_front();
            else done_byte = 8'($urandom);
            len       = (k < TMO) ? k + 1 : TMO;
            lat_k     = k;
            en_from   = cyc + 1;
            en_to     = cyc + len;
            done_at   = cyc + len + 1;
            done_port = gp;
            done_err  = (k >= TMO);
            free_at   = cyc + 1 + len + GAP;
         end
      end
   endtask

   task automatic run_cycle();
      bit busy_now, rst_now;
      @(posedge clk);
      #1;
      cyc++;
      rst_now  = rst_req || (rand_rst && $urandom_range(0, 499) == 0);
      busy_now = (cyc >= en_from) && (cyc <= en_to);
      for (int p = 0; p < 2; p++) begin
         if (keep_valid && !pend[p] && !wait_done[p]) pend[p] = 1'b1;
         if (auto_req && !pend[p] && !wait_done[p] && $urandom_range(0, 2) == 0)
            new_cmd(p, 16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      reset_n        = !rst_now;
      req0_valid     = pend[0];
      req0_data      = cmd_data[0];
      req0_slave     = cmd_slave[0];
      req0_operation = cmd_op[0];
      req1_valid     = pend[1];
      req1_data      = cmd_data[1];
      req1_slave     = cmd_slave[1];
      req1_operation = cmd_op[1];
      spi_incoming_data      = 8'($urandom);
      spi_end_of_transaction = 1'b0;
      if (busy_now && (cyc == en_from + lat_k)) begin
         spi_end_of_transaction = 1'b1;
         spi_incoming_data      = done_byte;
      end else if (!busy_now && (spur_force || (spur_en && $urandom_range(0, 7) == 0))) begin
         spi_end_of_transaction = 1'b1;
      end
      @(negedge clk);
      compare_and_update();
   endtask

   task automatic run_n(int n);
      for (int i = 0; i < n; i++) run_cycle();
   endtask

   function automatic bit busy_any();
      return pend[0] || pend[1] || wait_done[0] || wait_done[1] || (cyc < free_at);
   endfunction

   task automatic run_until_idle(int bound);
      int n;
      n = 0;
      while (busy_any() && n < bound) begin
         run_cycle();
         n++;
      end
      n_vec++;
      if (busy_any()) begin
         n_err++;
         $display("FAIL idle_wait cyc=%0d got=busy want=idle within %0d cycles", cyc, bound);
      end
   endtask

   initial begin
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; cmd_data[p] = '0; cmd_slave[p] = '0; cmd_op[p] = 1'b0;
         rdy_cyc[p] = -100; done_cyc[p] = -1; done_err_seen[p] = 1'b1;
         en_at_done[p] = 1'b1; done_rd[p] = '0;
      end
      model_reset();
      rst_req = 1'b1;
      run_n(3);
      rst_req = 1'b0;

      // single write on port 0, responder answers at BUSY cycle 10
      lat_q.push_back(10);
      new_cmd(0, 16'h1305, 2'd0, 1'b1);
      run_until_idle(200);
      check("a_latency", done_cyc[0] - rdy_cyc[0], 12);
      check("a_error", done_err_seen[0], 0);
      check("a_data", busy_data, 16'h1305);
      check("a_op", busy_op, 1);
      check("a_en_at_done", en_at_done[0], 0);

      // both ports held valid after reset: grants alternate starting at port 0
      rst_req = 1'b1;
      run_cycle();
      rst_req = 1'b0;
      act_grants.delete();
      repeat (4) lat_q.push_back(5);
      new_cmd(0, 16'h3202, 2'd0, 1'b0);
      new_cmd(1, 16'hC003, 2'd1, 1'b1);
      keep_valid = 1'b1;
      for (int n = 0; n < 300 && act_grants.size() < 4; n++) run_cycle();
      keep_valid = 1'b0;
      run_until_idle(200);
      check("b_grants", act_grants.size() >= 4, 1);
      if (act_grants.size() >= 4)
         for (int i = 0; i < 4; i++) check("b_order", act_grants[i], exp_order[i]);

      // reads: port 0 gets 0x3C, then port 1 gets 0xA5 without disturbing port 0
      lat_q.delete();
      byte_q.delete();
      lat_q.push_back(7);
      lat_q.push_back(7);
      byte_q.push_back(8'h3C);
      byte_q.push_back(8'hA5);
      new_cmd(0, 16'h8100, 2'd2, 1'b0);
      run_until_idle(200);
      new_cmd(1, 16'h8700, 2'd3, 1'b0);
      run_until_idle(200);
      check("c_rdata1", done_rd[1], 8'hA5);
      check("c_rdata0_kept", req0_rdata, 8'h3C);

      // silent responder on port 0 times out; queued port 1 command then completes
      lat_q.push_back(NEVER);
      lat_q.push_back(4);
      new_cmd(0, 16'h2211, 2'd1, 1'b1);
      new_cmd(1, 16'h4433, 2'd0, 1'b1);
      run_until_idle(300);
      check("d_tmo_len", done_cyc[0] - rdy_cyc[0], TMO + 1);
      check("d_tmo_err", done_err_seen[0], 1);
      check("d_tmo_en", en_at_done[0], 0);
      check("d_next_err", done_err_seen[1], 0);
      check("d_next_len", done_cyc[1] - rdy_cyc[1], 6);

      // reset in the middle of BUSY aborts without a done
      begin
         int n0;
         n0 = n_done_act;
         lat_q.push_back(12);
         new_cmd(0, 16'h5566, 2'd2, 1'b1);
         run_n(4);
         rst_req = 1'b1;
         run_cycle();
         rst_req = 1'b0;
         run_cycle();
         check("e_en_after_rst", spi_enable, 0);
         check("e_data_after_rst", spi_outgoing_data, 0);
         run_n(20);
         check("e_no_done", n_done_act - n0, 0);
         lat_q.push_back(3);
         new_cmd(1, 16'h7788, 2'd0, 1'b0);
         run_until_idle(200);
         check("e_fresh_done", n_done_act - n0, 1);
      end

      // end_of_transaction on the last BUSY cycle counts as success; spurious one in IDLE is ignored
      begin
         int n0;
         lat_q.push_back(TMO - 1);
         new_cmd(0, 16'h99AA, 2'd1, 1'b1);
         run_until_idle(200);
         check("f_coinc_err", done_err_seen[0], 0);
         check("f_coinc_len", done_cyc[0] - rdy_cyc[0], TMO + 1);
         n0 = n_done_act;
         spur_force = 1'b1;
         run_n(3);
         spur_force = 1'b0;
         run_n(3);
         check("f_spurious", n_done_act - n0, 0);
      end

      // random traffic with spurious pulses and occasional resets
      lat_q.delete();
      byte_q.delete();
      auto_req = 1'b1;
      spur_en  = 1'b1;
      rand_rst = 1'b1;
      run_n(4000);
      auto_req = 1'b0;
      rand_rst = 1'b0;
      run_until_idle(500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
